reg_wr_arbiter: RTL and testbench
=================================

Name: reg_wr_arbiter

Overview:
- Shares the register file's single write port between the core writeback path and the I2C slave engine.
- Assembles I2C byte writes into 16-bit words, high byte first.
- Arbitrates the core and I2C requesters. Core has priority, subject to an optional starvation guard.
- Drives registered write-enable, address and data into the register file. Sits between the core/I2C blocks and the register file.

Parameters:
- DATA_W, 16, register width in bits (must be 2x byte width)
- ADDR_W, 4, register index width (16 registers, index 0 hardwired zero)
- MAX_WAIT, 4, cycles a pending I2C word may be denied before it is forced through (guard feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core requests a register write this cycle
- core_addr  in  ADDR_W  core target register index
- core_data  in  DATA_W  core write data
- core_gnt  out  1  combinational; core write accepted this cycle
- i2c_byte_vld  in  1  one-cycle strobe, I2C byte available
- i2c_byte  in  8  I2C byte
- i2c_reg_sel  in  ADDR_W  I2C target register, sampled with the high byte
- i2c_busy  out  1  assembler not idle (high byte held or word pending)
- i2c_ovf  out  1  sticky: byte dropped because a word was still pending
- i2c_ovf_clr  in  1  clears i2c_ovf
- reg_we  out  1  register-file write enable (registered)
- reg_waddr  out  ADDR_W  register-file write index (registered)
- reg_wdata  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, rst=1) puts all outputs to 0: core_gnt, i2c_busy, i2c_ovf, reg_we, reg_waddr, reg_wdata. Assembler goes to IDLE, wait counter to 0, hold registers to 0.
- Assembler FSM has three states:
  - IDLE: on i2c_byte_vld, latch the byte as high byte and latch i2c_reg_sel; go to HAVE_HI.
  - HAVE_HI: on i2c_byte_vld, latch the low byte; go to PEND.
  - PEND: word pending; go back to IDLE in the cycle the I2C word is granted.
- Overflow in PEND: i2c_byte_vld with no grant that cycle means the byte is dropped and i2c_ovf is set. The state is unchanged.
- Grant in PEND: if the word is granted in the same cycle a byte arrives, the byte is treated as a new high byte and the FSM goes to HAVE_HI.
- Overflow flag precedence: i2c_ovf_clr and a new overflow in the same cycle leaves the flag set.
- Arbitration is combinational and evaluated each cycle:
  - If core_req and no forced I2C grant: core_gnt=1.
  - If PEND and (not core_req, or forced): I2C is granted and core_gnt=0.
- Write latency: the winner's address/data appear on reg_waddr/reg_wdata with reg_we=1 on the next rising edge. Exactly one write per cycle.
- Address-0 writes, from either source, are granted (they consume the slot and clear PEND). reg_we stays 0 for them and reg_waddr/reg_wdata hold their previous values.
- Idle output: with no grant, reg_we=0 and reg_waddr/reg_wdata hold.
- i2c_busy = (state != IDLE).
- Reset mid-operation abandons a partially assembled or pending word with no write issued. i2c_ovf is cleared.

Optional Feature:
- Macro: REG_WR_STARVE_GUARD_EN.
- Defined:
  - A wait counter increments each cycle the FSM is in PEND and not granted, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, the I2C word is forced that cycle and core_gnt=0.
  - The counter clears on the I2C grant and on reset.
- Undefined: strict core priority, no counter logic, and an I2C word may wait indefinitely under continuous core_req.

Decomposition:
- Shared package (reg_wr_pkg): ADDR_W/DATA_W defaults, the assembler state enum (IDLE, HAVE_HI, PEND), and the ZERO_REG=0 constant.
- One sub-module, i2c_word_assembler: FSM, hold registers and overflow flag. Its outputs are pend/addr/word; its input is grant.
- Arbiter, starvation counter and output registers stay in the top module.

Test Plan:
- Core only: core_req=1, core_addr=8, core_data=16'h1234 -> core_gnt=1 same cycle; next edge reg_we=1, reg_waddr=8, reg_wdata=16'h1234.
- I2C word: bytes 8'hAB then 8'hCD, i2c_reg_sel=6, core idle -> PEND after second byte; next cycle granted; then reg_we=1, reg_waddr=6, reg_wdata=16'hABCD; i2c_busy falls.
- Contention: I2C word in PEND plus core_req held high:
  - Guard undefined: core wins every cycle and I2C stays pending.
  - Guard defined, MAX_WAIT=4: I2C is forced on the 5th pending cycle with core_gnt=0 that cycle.
- Overflow: third byte 8'h55 while PEND with core holding the port -> byte dropped, i2c_ovf=1; i2c_ovf_clr pulse -> i2c_ovf=0; pending word later written unchanged.
- Zero register: core_req to addr 0 -> core_gnt=1, reg_we stays 0; I2C word to addr 0 -> PEND clears, no write issued.
- Async reset in HAVE_HI with i2c_ovf=1: assert rst between edges -> all outputs 0 immediately; after release, the next byte is treated as a high byte.

Source files
------------

// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The guarded starvation feature in the top is enabled by REG_WR_STARVE_GUARD_EN.
package reg_wr_pkg;

   localparam int REG_DATA_W = 16;
   localparam int REG_ADDR_W = 4;
   localparam int BYTE_W     = 8;
   localparam int ZERO_REG   = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HAVE_HI = 2'd1,
      PEND    = 2'd2
   } asm_state_t;

endpackage

// File: rtl/i2c_word_assembler.sv
// Packs two I2C byte strobes into one register word (high byte first) and
// holds it pending until the arbiter grants it; flags bytes lost while pending.
module i2c_word_assembler
   import reg_wr_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_vld,
   input  logic [BYTE_W-1:0] byte_data,
   input  logic [ADDR_W-1:0] reg_sel,
   input  logic              grant,
   input  logic              ovf_clr,
   output logic              pend,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] word,
   output logic              busy,
   output logic              ovf
);

   localparam int HALF_W = DATA_W / 2;

   asm_state_t        state;
   asm_state_t        state_nxt;
   logic              load_hi;
   logic              load_lo;
   logic              drop;
   logic [HALF_W-1:0] hi_q;
   logic [HALF_W-1:0] lo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A byte arriving in the same cycle the pending word leaves starts the next word.
   always_comb begin
      state_nxt = state;
      load_hi   = 1'b0;
      load_lo   = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (byte_vld) begin
               load_hi   = 1'b1;
               state_nxt = HAVE_HI;
            end
         end
         HAVE_HI: begin
            if (byte_vld) begin
               load_lo   = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (grant) begin
               if (byte_vld) begin
                  load_hi   = 1'b1;
                  state_nxt = HAVE_HI;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (byte_vld) begin
               drop = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A fresh overflow outranks a simultaneous clear so no drop goes unreported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         addr <= '0;
         ovf  <= 1'b0;
      end else begin
         if (load_hi) begin
            hi_q <= HALF_W'(byte_data);
            addr <= reg_sel;
         end
         if (load_lo) begin
            lo_q <= HALF_W'(byte_data);
         end
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   assign pend = (state == PEND);
   assign busy = (state != IDLE);
   assign word = {hi_q, lo_q};

endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the register file write port between the core and the I2C engine.
// Define REG_WR_STARVE_GUARD_EN to force a long-waiting I2C word past the core.
module reg_wr_arbiter
   import reg_wr_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
`ifdef REG_WR_STARVE_GUARD_EN
   ,
   parameter int MAX_WAIT = 4
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_data,
   output logic              core_gnt,
   input  logic              i2c_byte_vld,
   input  logic [BYTE_W-1:0] i2c_byte,
   input  logic [ADDR_W-1:0] i2c_reg_sel,
   output logic              i2c_busy,
   output logic              i2c_ovf,
   input  logic              i2c_ovf_clr,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_waddr,
   output logic [DATA_W-1:0] reg_wdata
);

   logic              i2c_pend;
   logic              i2c_gnt;
   logic              force_i2c;
   logic [ADDR_W-1:0] i2c_addr;
   logic [DATA_W-1:0] i2c_word;

   i2c_word_assembler #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .byte_vld  (i2c_byte_vld),
      .byte_data (i2c_byte),
      .reg_sel   (i2c_reg_sel),
      .grant     (i2c_gnt),
      .ovf_clr   (i2c_ovf_clr),
      .pend      (i2c_pend),
      .addr      (i2c_addr),
      .word      (i2c_word),
      .busy      (i2c_busy),
      .ovf       (i2c_ovf)
   );

`ifdef REG_WR_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counts denied pending cycles; reaching the limit hands the next slot to I2C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (i2c_gnt) begin
         wait_cnt <= '0;
      end else if (i2c_pend && (wait_cnt != CNT_W'(MAX_WAIT))) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign force_i2c = i2c_pend && (wait_cnt == CNT_W'(MAX_WAIT));
`else
   assign force_i2c = 1'b0;
`endif

   // Grants are held low during reset so nothing is accepted that will not be written.
   always_comb begin
      core_gnt = 1'b0;
      i2c_gnt  = 1'b0;
      if (!rst) begin
         if (core_req && !force_i2c) begin
            core_gnt = 1'b1;
         end else if (i2c_pend) begin
            i2c_gnt = 1'b1;
         end
      end
   end

   // Writes to the hardwired zero register use up the slot but never reach the file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_we    <= 1'b0;
         reg_waddr <= '0;
         reg_wdata <= '0;
      end else begin
         reg_we <= 1'b0;
         if (core_gnt && (core_addr != ADDR_W'(ZERO_REG))) begin
            reg_we    <= 1'b1;
            reg_waddr <= core_addr;
            reg_wdata <= core_data;
         end else if (i2c_gnt && (i2c_addr != ADDR_W'(ZERO_REG))) begin
            reg_we    <= 1'b1;
            reg_waddr <= i2c_addr;
            reg_wdata <= i2c_word;
         end
      end
   end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed table, corner sequences and
// randomized traffic against a word-level model; honours REG_WR_STARVE_GUARD_EN.
module tb_reg_wr_arbiter;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int MAX_WAIT = 4;
`ifdef REG_WR_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              core_req;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_data;
   logic              core_gnt;
   logic              i2c_byte_vld;
   logic [7:0]        i2c_byte;
   logic [ADDR_W-1:0] i2c_reg_sel;
   logic              i2c_busy;
   logic              i2c_ovf;
   logic              i2c_ovf_clr;
   logic              reg_we;
   logic [ADDR_W-1:0] reg_waddr;
   logic [DATA_W-1:0] reg_wdata;

   reg_wr_arbiter #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .core_req     (core_req),
      .core_addr    (core_addr),
      .core_data    (core_data),
      .core_gnt     (core_gnt),
      .i2c_byte_vld (i2c_byte_vld),
      .i2c_byte     (i2c_byte),
      .i2c_reg_sel  (i2c_reg_sel),
      .i2c_busy     (i2c_busy),
      .i2c_ovf      (i2c_ovf),
      .i2c_ovf_clr  (i2c_ovf_clr),
      .reg_we       (reg_we),
      .reg_waddr    (reg_waddr),
      .reg_wdata    (reg_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Word-level reference model
   bit          m_have_hi;
   logic [7:0]  m_hi;
   logic [3:0]  m_sel;
   bit          m_pend;
   logic [3:0]  m_pend_addr;
   logic [15:0] m_pend_word;
   int          m_wait;
   bit          m_ovf;
   bit          m_we;
   logic [3:0]  m_waddr;
   logic [15:0] m_wdata;

   logic [15:0] seen_addr5;

   typedef struct {
      bit          cr;
      logic [3:0]  ca;
      logic [15:0] cd;
      bit          v;
      logic [7:0]  b;
      logic [3:0]  s;
      bit          clr;
      bit          e_gnt;
      bit          e_busy;
      bit          e_ovf;
      bit          e_we;
      logic [3:0]  e_waddr;
      logic [15:0] e_wdata;
   } vec_t;

   vec_t tbl [12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_have_hi   = 1'b0;
      m_hi        = '0;
      m_sel       = '0;
      m_pend      = 1'b0;
      m_pend_addr = '0;
      m_pend_word = '0;
      m_wait      = 0;
      m_ovf       = 1'b0;
      m_we        = 1'b0;
      m_waddr     = '0;
      m_wdata     = '0;
   endtask

   // One clock: drive at negedge, compare every output against the model, then
   // advance the model by what the next rising edge should do.
   task automatic applyStimulus(input bit cr, input logic [3:0] ca, input logic [15:0] cd,
                                input bit v, input logic [7:0] b, input logic [3:0] s,
                                input bit clr);
      bit forced;
      bit e_gnt;
      bit i2c_win;
      @(negedge clk);
      core_req     = cr;
      core_addr    = ca;
      core_data    = cd;
      i2c_byte_vld = v;
      i2c_byte     = b;
      i2c_reg_sel  = s;
      i2c_ovf_clr  = clr;
      #1;
      forced  = GUARD && m_pend && (m_wait == MAX_WAIT);
      e_gnt   = cr && !forced;
      i2c_win = m_pend && !e_gnt;
      checkOutput("core_gnt", core_gnt, e_gnt);
      checkOutput("i2c_busy", i2c_busy, m_pend || m_have_hi);
      checkOutput("i2c_ovf", i2c_ovf, m_ovf);
      checkOutput("reg_we", reg_we, m_we);
      checkOutput("reg_waddr", reg_waddr, m_waddr);
      checkOutput("reg_wdata", reg_wdata, m_wdata);
      if (reg_we === 1'b1 && reg_waddr === 4'd5) seen_addr5 = reg_wdata;

      if (e_gnt && ca != 4'd0) begin
         m_we = 1'b1; m_waddr = ca; m_wdata = cd;
      end else if (i2c_win && m_pend_addr != 4'd0) begin
         m_we = 1'b1; m_waddr = m_pend_addr; m_wdata = m_pend_word;
      end else begin
         m_we = 1'b0;
      end
      if (GUARD) begin
         if (i2c_win) m_wait = 0;
         else if (m_pend && m_wait < MAX_WAIT) m_wait = m_wait + 1;
      end
      if (v && m_pend && !i2c_win) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (i2c_win) m_pend = 1'b0;
      if (v && !m_pend) begin
         if (m_have_hi) begin
            m_pend      = 1'b1;
            m_pend_word = {m_hi, b};
            m_pend_addr = m_sel;
            m_have_hi   = 1'b0;
         end else begin
            m_have_hi = 1'b1;
            m_hi      = b;
            m_sel     = s;
         end
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_core_gnt"}, core_gnt, 1'b0);
      checkOutput({tag, "_i2c_busy"}, i2c_busy, 1'b0);
      checkOutput({tag, "_i2c_ovf"}, i2c_ovf, 1'b0);
      checkOutput({tag, "_reg_we"}, reg_we, 1'b0);
      checkOutput({tag, "_reg_waddr"}, reg_waddr, 4'd0);
      checkOutput({tag, "_reg_wdata"}, reg_wdata, 16'h0000);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0]  = '{1'b1, 4'd8, 16'h1234, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
      tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'hAB, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 16'h1234};
      tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'hCD, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 16'h1234};
      tbl[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 16'h1234};
      tbl[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 16'hABCD};
      tbl[5]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'h11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'h22, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[10] = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'hABCD};
      tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'hBEEF};

      seen_addr5   = 16'h0000;
      rst          = 1'b1;
      core_req     = 1'b1;
      core_addr    = 4'd8;
      core_data    = 16'h5A5A;
      i2c_byte_vld = 1'b0;
      i2c_byte     = 8'h00;
      i2c_reg_sel  = 4'd0;
      i2c_ovf_clr  = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkAllZero("reset");
      core_req  = 1'b0;
      core_addr = 4'd0;
      core_data = 16'h0000;
      rst       = 1'b0;

      $display("[TB] directed table");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].cr, tbl[i].ca, tbl[i].cd, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].clr);
         checkOutput($sformatf("tbl%0d_gnt", i), core_gnt, tbl[i].e_gnt);
         checkOutput($sformatf("tbl%0d_busy", i), i2c_busy, tbl[i].e_busy);
         checkOutput($sformatf("tbl%0d_ovf", i), i2c_ovf, tbl[i].e_ovf);
         checkOutput($sformatf("tbl%0d_we", i), reg_we, tbl[i].e_we);
         checkOutput($sformatf("tbl%0d_waddr", i), reg_waddr, tbl[i].e_waddr);
         checkOutput($sformatf("tbl%0d_wdata", i), reg_wdata, tbl[i].e_wdata);
      end

      $display("[TB] contention and overflow");
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'h12, 4'd5, 1'b0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'h34, 4'd0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 4'd9, 16'h9000 + 16'(k), (k == 2 || k == 4),
                       (k == 2) ? 8'h55 : 8'h66, 4'd1, (k == 3 || k == 4 || k == 6));
         checkOutput($sformatf("contend%0d_gnt", k), core_gnt, GUARD ? (k != 5) : 1'b1);
         if (k == 3) checkOutput("ovf_set", i2c_ovf, 1'b1);
         if (k == 4) checkOutput("ovf_clr", i2c_ovf, 1'b0);
         if (k == 5) checkOutput("ovf_beats_clr", i2c_ovf, 1'b1);
         if (k == 7) checkOutput("ovf_clr2", i2c_ovf, 1'b0);
         if (k == 8) checkOutput("starve_busy", i2c_busy, GUARD ? 1'b0 : 1'b1);
      end
      repeat (3) idleCycle();
      checkOutput("pend_word_intact", seen_addr5, 16'h1234);

      $display("[TB] async reset mid-word");
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'h01, 4'd2, 1'b0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'h02, 4'd0, 1'b0);
      applyStimulus(1'b1, 4'd9, 16'h7777, 1'b1, 8'h03, 4'd0, 1'b0);
      idleCycle();
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'h04, 4'd3, 1'b0);
      idleCycle();
      checkOutput("pre_rst_busy", i2c_busy, 1'b1);
      checkOutput("pre_rst_ovf", i2c_ovf, 1'b1);
      checkOutput("pre_rst_waddr", reg_waddr, 4'd2);
      @(posedge clk);
      #3;
      rst       = 1'b1;
      core_req  = 1'b1;
      core_addr = 4'd4;
      core_data = 16'hC0DE;
      #1;
      checkAllZero("async_rst");
      modelReset();
      @(negedge clk);
      core_req  = 1'b0;
      core_addr = 4'd0;
      core_data = 16'h0000;
      rst       = 1'b0;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'hAA, 4'd7, 1'b0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 8'hBB, 4'd1, 1'b0);
      idleCycle();
      idleCycle();
      checkOutput("post_rst_we", reg_we, 1'b1);
      checkOutput("post_rst_waddr", reg_waddr, 4'd7);
      checkOutput("post_rst_wdata", reg_wdata, 16'hAABB);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus((n < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0),
                       4'($urandom_range(0, 15)), 16'($urandom),
                       ($urandom_range(0, 9) < 4), 8'($urandom),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
